// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac: sample FIFO paced by an external rate clock, feeding a
// glitch-free PWM output stage whose duty updates only at period boundaries.
// Optional feature macro: AUDIO_PWM_UNDERRUN_MIDSCALE_EN
//   defined   -> an underrun loads midscale (2^(DW-1)) as the next duty
//   undefined -> an underrun keeps the last played duty
module audio_pwm_dac #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_rate_clk,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DW-1:0]                 s_data,
    output logic                          o_pwm,
    output logic                          o_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
`ifdef AUDIO_PWM_UNDERRUN_MIDSCALE_EN
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
`endif

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic          underrun_q, underrun_d;
    logic [DW-1:0] pending_q, pending_d;
    logic [DW-1:0] active_q, active_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          pwm_q, pwm_d;
    logic          push, pop, strobe;

    assign s_ready    = (count_q != FULL_LVL);
    assign o_level    = count_q;
    assign o_underrun = underrun_q;
    assign o_pwm      = pwm_q;

    // Next-state: FIFO bookkeeping, rate-strobe pop/underrun, PWM counter and duty
    always_comb begin
        push       = s_valid && s_ready;
        strobe     = sync2_q && !sync3_q;
        pop        = strobe && (count_q != '0);
        underrun_d = strobe && (count_q == '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            pending_d = mem_q[rd_ptr_q];
        end
`ifdef AUDIO_PWM_UNDERRUN_MIDSCALE_EN
        if (underrun_d) begin
            pending_d = MIDSCALE;
        end
`endif
        // Push on an empty FIFO alongside a strobe is not bypassed: the
        // underrun fires and the sample simply lands in the FIFO.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        cnt_d    = cnt_q + 1'b1;
        active_d = (cnt_q == '1) ? pending_q : active_q;
        pwm_d    = (cnt_q < active_q);
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            underrun_q <= 1'b0;
            pending_q  <= '0;
            active_q   <= '0;
            cnt_q      <= '0;
            pwm_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sync1_q    <= i_rate_clk;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            underrun_q <= underrun_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
        end
    end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Bench for audio_pwm_dac (DW=8, FIFO_DEPTH=4). Honors the same
// AUDIO_PWM_UNDERRUN_MIDSCALE_EN macro as the design for underrun duty.
module tb_audio_pwm_dac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rate_clk = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       o_pwm;
    logic       o_underrun;
    logic [2:0] o_level;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int pend_model = 0;

    typedef struct {
        logic [7:0] sample;
        int         exp_high;
    } vec_t;
    vec_t vecs[7];
    logic [7:0] fill[4];

    audio_pwm_dac #(.DW(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rate_clk (i_rate_clk),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .o_pwm      (o_pwm),
        .o_underrun (o_underrun),
        .o_level    (o_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input int exp);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("push_timeout", 1, 0);
        tick();
        s_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    // One rate-clock pulse; rise sampled at edge k, effects expected at k+2
    task automatic rate_edge();
        i_rate_clk = 1'b1;
        tick();
        chk("lvl_k", int'(o_level), exp_q.size());
        chk("unr_k", int'(o_underrun), 0);
        tick();
        chk("lvl_k1", int'(o_level), exp_q.size());
        chk("unr_k1", int'(o_underrun), 0);
        tick();
        if (exp_q.size() > 0) begin
            pend_model = exp_q.pop_front();
            chk("unr_k2", int'(o_underrun), 0);
        end else begin
            chk("unr_k2", int'(o_underrun), 1);
`ifdef AUDIO_PWM_UNDERRUN_MIDSCALE_EN
            pend_model = 128;
`endif
        end
        chk("lvl_k2", int'(o_level), exp_q.size());
        tick();
        chk("unr_k3", int'(o_underrun), 0);
        i_rate_clk = 1'b0;
        repeat (3) tick();
    endtask

    // Any 256-cycle window after the duty settles holds exactly duty highs
    task automatic measure(input string name, input int exp);
        int h = 0;
        repeat (300) tick();
        repeat (256) begin
            if (o_pwm) h++;
            tick();
        end
        chk(name, h, exp);
    endtask

    initial begin
        int   seen;
        int   n;
        int   run;
        int   bad;
        int   big;
        bit   started;
        logic prev;

        vecs[0] = '{8'h40, 64};
        vecs[1] = '{8'h00, 0};
        vecs[2] = '{8'hFF, 255};
        vecs[3] = '{8'h80, 128};
        vecs[4] = '{8'h01, 1};
        vecs[5] = '{8'hC0, 192};
        vecs[6] = '{8'h40, 64};
        fill[0] = 8'h10; fill[1] = 8'h20; fill[2] = 8'h30; fill[3] = 8'h40;

        // Reset with random inputs
        #1;
        chk("rst_pwm", int'(o_pwm), 0);
        chk("rst_unr", int'(o_underrun), 0);
        chk("rst_lvl", int'(o_level), 0);
        chk("rst_ready", int'(s_ready), 1);
        seen = 0;
        repeat (310) begin
            s_valid    = 1'($urandom_range(0, 1));
            s_data     = 8'($urandom);
            i_rate_clk = 1'($urandom_range(0, 1));
            tick();
            if (o_pwm || o_underrun || o_level != 0 || !s_ready) seen = 1;
        end
        chk("rst_outputs_held", seen, 0);
        s_valid = 1'b0; i_rate_clk = 1'b0; s_data = '0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // Table-driven duty vectors
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].sample, vecs[i].exp_high);
            chk("vec_level", int'(o_level), 1);
            rate_edge();
            measure($sformatf("duty_%02h", vecs[i].sample), pend_model);
        end

        // Underrun on empty FIFO
        rate_edge();
        measure("underrun_duty", pend_model);

        // Fill / backpressure
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = fill[i];
            chk("fill_ready", int'(s_ready), 1);
            tick();
            exp_q.push_back(int'(fill[i]));
            chk("fill_level", int'(o_level), i + 1);
        end
        s_data = 8'h50;
        chk("full_ready", int'(s_ready), 0);
        repeat (5) tick();
        chk("full_hold_level", int'(o_level), 4);
        rate_edge();
        exp_q.push_back(8'h50);
        s_valid = 1'b0;
        chk("refill_level", int'(o_level), 4);
        chk("refill_ready", int'(s_ready), 0);
        // Drain faster than one edge per period; only the last value plays
        repeat (4) rate_edge();
        measure("drain_last_duty", pend_model);

        // Duty change lands only at a period boundary: every high run is old or new width
        push(8'hC0, 192);
        rate_edge();
        run = 0; bad = 0; big = 0; started = 0;
        prev = o_pwm;
        repeat (700) begin
            tick();
            if (o_pwm) begin
                if (!prev) begin
                    started = 1;
                    run = 0;
                end
                run++;
            end else if (prev && started) begin
                if (run == 192) big++;
                else if (run != 80) bad++;
            end
            prev = o_pwm;
        end
        chk("glitch_bad_runs", bad, 0);
        chk("new_duty_seen", int'(big > 0), 1);

        // Reset mid-operation
        push(8'h11, 17);
        push(8'h22, 34);
        push(8'h33, 51);
        chk("pre_reset_level", int'(o_level), 3);
        n = 0;
        while (!o_pwm && n < 600) begin
            tick();
            n++;
        end
        chk("pre_reset_pwm", int'(o_pwm), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_pwm", int'(o_pwm), 0);
        chk("midrst_level", int'(o_level), 0);
        chk("midrst_ready", int'(s_ready), 1);
        exp_q.delete();
        pend_model = 0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        rate_edge();
        measure("post_reset_duty", pend_model);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
